// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic accelerator memory responder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY     = 2'd1,
    ST_COMPLETE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_W   = 2'd0,
    SEL_X   = 2'd1,
    SEL_O   = 2'd2,
    SEL_RSV = 2'd3
  } host_sel_e;

  // Word width in bits from element width and elements per word
  function automatic int word_width(input int dw, input int rows);
    return dw * rows;
  endfunction

  // Byte-to-word shift: log2 of bytes per word
  function automatic int word_shift(input int ww);
    return $clog2(ww / 8);
  endfunction

  // RAM address width, never below one bit
  function automatic int addr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Accelerator byte address to word index (no wrap: full 32-bit result)
  function automatic logic [31:0] byte_to_word(input logic [31:0] addr, input int sh);
    return addr >> sh;
  endfunction

endpackage

// File: rtl/systolic_sram.sv
// Single-port-write, single-port-read RAM with registered read data; no reset on contents.
// Latency: write lands on the edge; read data valid one cycle after re.
// Backpressure: none, every request is accepted; rdata holds when re is low.
module systolic_sram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 128,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; callers guarantee waddr < DEPTH
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; same-address write in the same cycle returns old contents
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/systolic_mem_responder.sv
// W/X/O memory model for a systolic accelerator with host access, job FSM and error flag.
// Latency: accelerator and host reads 1 cycle; O writes land on the same edge.
// Backpressure: none; illegal or out-of-range accesses are dropped and raise sticky err.
module systolic_mem_responder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_ROWS = 4,
  parameter int N1         = 4,
  parameter int N2         = 4,
  localparam int WORD_W    = word_width(DATA_WIDTH, ARRAY_ROWS)
) (
  input  logic              clk,
  input  logic              srstn,
  input  logic              start,
  input  logic              done,
  input  logic [31:0]       w_addr,
  input  logic              mem_read_w,
  output logic [WORD_W-1:0] w_rdata,
  input  logic [31:0]       x_addr,
  input  logic              mem_read_x,
  output logic [WORD_W-1:0] x_rdata,
  input  logic [31:0]       mem_write_addr,
  input  logic              mem_write,
  input  logic [WORD_W-1:0] mem_wdata,
  input  logic [1:0]        host_sel,
  input  logic [15:0]       host_addr,
  input  logic              host_we,
  input  logic              host_re,
  input  logic [WORD_W-1:0] host_wdata,
  output logic [WORD_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              busy,
  output logic [15:0]       wr_count,
  output logic              err
);

  localparam int          SH      = word_shift(WORD_W);
  localparam int unsigned W_DEPTH = N1 * N1 + N2 * N2;
  localparam int unsigned X_DEPTH = N1 * N2;
  localparam int unsigned O_DEPTH = N1 * N2;
  localparam int          W_AW    = addr_bits(W_DEPTH);
  localparam int          X_AW    = addr_bits(X_DEPTH);
  localparam int          O_AW    = addr_bits(O_DEPTH);

  state_e      state;
  host_sel_e   sel, h_src_q;
  logic [31:0] w_idx, x_idx, o_idx, h_idx;
  logic        w_ok, x_ok, o_ok, h_ok;
  logic        h_wr, h_rd, in_busy, job_start;
  logic        w_we, w_re, x_we, x_re, o_we, o_re;
  logic        h_zero, err_set, err_clr;
  logic [W_AW-1:0] w_raddr;
  logic [X_AW-1:0] x_raddr;
  logic [WORD_W-1:0] w_q, x_q, o_q;
  logic [WORD_W-1:0] w_hold, x_hold, h_hold;
  logic        w_vld_q, w_zero_q, x_vld_q, x_zero_q, h_zero_q;

  assign sel   = host_sel_e'(host_sel);
  assign w_idx = byte_to_word(w_addr, SH);
  assign x_idx = byte_to_word(x_addr, SH);
  assign o_idx = byte_to_word(mem_write_addr, SH);
  assign h_idx = {16'd0, host_addr};
  assign w_ok  = w_idx < W_DEPTH;
  assign x_ok  = x_idx < X_DEPTH;
  assign o_ok  = o_idx < O_DEPTH;

  // Write wins when both host strobes are set; the read is suppressed entirely
  assign h_wr    = host_we;
  assign h_rd    = host_re & ~host_we;
  assign in_busy = (state == ST_BUSY);

  // Host index range check against the selected target's depth
  always_comb begin
    h_ok = 1'b0;
    case (sel)
      SEL_W:   h_ok = h_idx < W_DEPTH;
      SEL_X:   h_ok = h_idx < X_DEPTH;
      SEL_O:   h_ok = h_idx < O_DEPTH;
      default: h_ok = 1'b0;
    endcase
  end

  // W/X share one read port between accelerator and host; the accelerator wins
  // and a colliding host read returns zero with err raised.
  assign w_we    = srstn & h_wr & (sel == SEL_W) & h_ok & ~in_busy;
  assign w_re    = (mem_read_w & w_ok) | (h_rd & (sel == SEL_W) & h_ok & ~mem_read_w);
  assign w_raddr = mem_read_w ? w_idx[W_AW-1:0] : host_addr[W_AW-1:0];
  assign x_we    = srstn & h_wr & (sel == SEL_X) & h_ok & ~in_busy;
  assign x_re    = (mem_read_x & x_ok) | (h_rd & (sel == SEL_X) & h_ok & ~mem_read_x);
  assign x_raddr = mem_read_x ? x_idx[X_AW-1:0] : host_addr[X_AW-1:0];
  // srstn gates the O write so nothing lands while the job is being abandoned
  assign o_we    = srstn & mem_write & o_ok;
  assign o_re    = h_rd & (sel == SEL_O) & h_ok;

  assign h_zero  = ~h_ok | ((sel == SEL_W) & mem_read_w) | ((sel == SEL_X) & mem_read_x);
  assign err_set = (h_wr & (~h_ok | (sel == SEL_O) | in_busy))
                 | (h_rd & (sel != SEL_RSV) & h_zero)
                 | (mem_read_w & ~w_ok) | (mem_read_x & ~x_ok) | (mem_write & ~o_ok);
  assign err_clr = h_rd & (sel == SEL_RSV);
  assign job_start = start & ((state == ST_IDLE) | (state == ST_COMPLETE));

  systolic_sram #(.DEPTH(W_DEPTH), .WIDTH(WORD_W), .AW(W_AW)) u_w_ram (
    .clk(clk), .we(w_we), .waddr(host_addr[W_AW-1:0]), .wdata(host_wdata),
    .re(w_re), .raddr(w_raddr), .rdata(w_q)
  );

  systolic_sram #(.DEPTH(X_DEPTH), .WIDTH(WORD_W), .AW(X_AW)) u_x_ram (
    .clk(clk), .we(x_we), .waddr(host_addr[X_AW-1:0]), .wdata(host_wdata),
    .re(x_re), .raddr(x_raddr), .rdata(x_q)
  );

  systolic_sram #(.DEPTH(O_DEPTH), .WIDTH(WORD_W), .AW(O_AW)) u_o_ram (
    .clk(clk), .we(o_we), .waddr(o_idx[O_AW-1:0]), .wdata(mem_wdata),
    .re(o_re), .raddr(host_addr[O_AW-1:0]), .rdata(o_q)
  );

  // Job FSM with registered busy flag
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_BUSY;
          busy  <= 1'b1;
        end
        ST_BUSY: if (done) begin
          state <= ST_COMPLETE;
          busy  <= 1'b0;
        end
        ST_COMPLETE: if (start) begin
          state <= ST_BUSY;
          busy  <= 1'b1;
        end else if (h_rd && sel == SEL_O && h_idx == O_DEPTH - 1) begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output-word counter: cleared on job start, saturating increment per accepted write
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn)                              wr_count <= 16'd0;
    else if (job_start)                      wr_count <= 16'd0;
    else if (o_we && wr_count != 16'hFFFF)   wr_count <= wr_count + 16'd1;
  end

  // Sticky error: a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  // Read routing tags and hold registers so outputs keep their last value between reads
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      w_vld_q     <= 1'b0;
      w_zero_q    <= 1'b0;
      x_vld_q     <= 1'b0;
      x_zero_q    <= 1'b0;
      host_rvalid <= 1'b0;
      h_zero_q    <= 1'b0;
      h_src_q     <= SEL_W;
      w_hold      <= '0;
      x_hold      <= '0;
      h_hold      <= '0;
    end else begin
      w_vld_q     <= mem_read_w;
      w_zero_q    <= ~w_ok;
      x_vld_q     <= mem_read_x;
      x_zero_q    <= ~x_ok;
      host_rvalid <= h_rd;
      h_zero_q    <= h_zero;
      h_src_q     <= sel;
      w_hold      <= w_rdata;
      x_hold      <= x_rdata;
      h_hold      <= host_rdata;
    end
  end

  assign w_rdata = w_vld_q ? (w_zero_q ? '0 : w_q) : w_hold;
  assign x_rdata = x_vld_q ? (x_zero_q ? '0 : x_q) : x_hold;

  // Host read data selected by the target latched with the request
  always_comb begin
    host_rdata = h_hold;
    if (host_rvalid) begin
      if (h_zero_q) begin
        host_rdata = '0;
      end else begin
        case (h_src_q)
          SEL_W:   host_rdata = w_q;
          SEL_X:   host_rdata = x_q;
          SEL_O:   host_rdata = o_q;
          default: host_rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_mem_responder.sv
// Directed bench for systolic_mem_responder with hand-computed expectations.
// Latency: checks sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_systolic_mem_responder;

  localparam int WW = 128;

  logic          clk = 1'b0;
  logic          srstn = 1'b1;
  logic          start = 1'b0, done = 1'b0;
  logic [31:0]   w_addr = '0, x_addr = '0, mem_write_addr = '0;
  logic          mem_read_w = 1'b0, mem_read_x = 1'b0, mem_write = 1'b0;
  logic [WW-1:0] mem_wdata = '0, host_wdata = '0;
  logic [1:0]    host_sel = '0;
  logic [15:0]   host_addr = '0;
  logic          host_we = 1'b0, host_re = 1'b0;
  logic [WW-1:0] w_rdata, x_rdata, host_rdata;
  logic          host_rvalid, busy, err;
  logic [15:0]   wr_count;

  int n_vec = 0;
  int n_bad = 0;

  systolic_mem_responder dut (
    .clk(clk), .srstn(srstn), .start(start), .done(done),
    .w_addr(w_addr), .mem_read_w(mem_read_w), .w_rdata(w_rdata),
    .x_addr(x_addr), .mem_read_x(mem_read_x), .x_rdata(x_rdata),
    .mem_write_addr(mem_write_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .host_sel(host_sel), .host_addr(host_addr), .host_we(host_we), .host_re(host_re),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .busy(busy), .wr_count(wr_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [1:0] s, input logic [15:0] a, input logic [WW-1:0] d);
    host_sel = s; host_addr = a; host_wdata = d; host_we = 1'b1;
    tick();
    host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [1:0] s, input logic [15:0] a);
    host_sel = s; host_addr = a; host_re = 1'b1;
    tick();
    host_re = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 srstn = 1'b0;
    #1;
    chk("rst_busy", WW'(busy), WW'(0));
    chk("rst_wr_count", WW'(wr_count), WW'(0));
    chk("rst_err", WW'(err), WW'(0));
    chk("rst_rvalid", WW'(host_rvalid), WW'(0));
    chk("rst_w_rdata", w_rdata, '0);
    tick(); tick();
    srstn = 1'b1;
    tick();

    // Load W as a 4x4 diagonal-of-2 pattern plus a marker in the last word
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        host_wr(2'd0, 16'(i * 4 + j), (i == j) ? WW'(2) : WW'(0));
    host_wr(2'd0, 16'd31, WW'(32'hBEEF));
    host_wr(2'd1, 16'd0, WW'(32'h1234));
    chk("load_err", WW'(err), WW'(0));

    // Accelerator W read at byte 0x50 -> word 5 -> diagonal element
    w_addr = 32'h50; mem_read_w = 1'b1;
    tick();
    mem_read_w = 1'b0;
    chk("w_read_0x50", w_rdata, WW'(2));
    w_addr = 32'h40;
    tick();
    chk("w_hold", w_rdata, WW'(2));
    mem_read_w = 1'b1;
    tick();
    mem_read_w = 1'b0;
    chk("w_read_0x40", w_rdata, WW'(0));

    // Host W reads: in range, last index, one past the end
    host_rd(2'd0, 16'd10);
    chk("h_w10_data", host_rdata, WW'(2));
    chk("h_w10_rvalid", WW'(host_rvalid), WW'(1));
    chk("w_rdata_untouched", w_rdata, WW'(0));
    host_rd(2'd0, 16'd31);
    chk("h_w31_data", host_rdata, WW'(32'hBEEF));
    chk("h_w31_err", WW'(err), WW'(0));
    tick();
    chk("rvalid_pulse", WW'(host_rvalid), WW'(0));
    host_rd(2'd0, 16'd32);
    chk("h_w32_data", host_rdata, '0);
    chk("h_w32_err", WW'(err), WW'(1));
    host_rd(2'd3, 16'd0);
    chk("err_clear", WW'(err), WW'(0));

    // Simultaneous write and read: only the write happens
    host_sel = 2'd0; host_addr = 16'd20; host_wdata = WW'(8'h55);
    host_we = 1'b1; host_re = 1'b1;
    tick();
    host_we = 1'b0; host_re = 1'b0;
    chk("we_re_no_rvalid", WW'(host_rvalid), WW'(0));
    host_rd(2'd0, 16'd20);
    chk("we_re_written", host_rdata, WW'(8'h55));

    // Job start and 16 output writes
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("job_busy", WW'(busy), WW'(1));
    chk("job_count0", WW'(wr_count), WW'(0));
    mem_write = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_write_addr = 32'(i * 16);
      mem_wdata = WW'(i);
      tick();
    end
    mem_write = 1'b0;
    chk("wr_count16", WW'(wr_count), WW'(16));
    host_rd(2'd2, 16'd5);
    chk("o5", host_rdata, WW'(5));

    // Same-edge write and host read of O[3] returns old contents
    mem_write = 1'b1; mem_write_addr = 32'h30; mem_wdata = WW'(8'hAA);
    host_sel = 2'd2; host_addr = 16'd3; host_re = 1'b1;
    tick();
    mem_write = 1'b0; host_re = 1'b0;
    chk("o3_old", host_rdata, WW'(3));
    chk("wr_count17", WW'(wr_count), WW'(17));
    host_rd(2'd2, 16'd3);
    chk("o3_new", host_rdata, WW'(8'hAA));

    // Host X write rejected while busy
    host_wr(2'd1, 16'd0, WW'(7));
    chk("busy_wr_err", WW'(err), WW'(1));
    host_rd(2'd1, 16'd0);
    chk("x0_unchanged", host_rdata, WW'(32'h1234));
    host_rd(2'd3, 16'd0);
    chk("sel3_err_clr", WW'(err), WW'(0));
    chk("sel3_data", host_rdata, '0);

    // Host O write always rejected
    host_wr(2'd2, 16'd0, WW'(99));
    chk("o_wr_err", WW'(err), WW'(1));
    host_rd(2'd2, 16'd0);
    chk("o0_unchanged", host_rdata, WW'(0));
    host_rd(2'd3, 16'd0);

    // Accelerator X reads: in range, then index 16 out of range
    x_addr = 32'h0; mem_read_x = 1'b1;
    tick();
    chk("x_read0", x_rdata, WW'(32'h1234));
    x_addr = 32'h100;
    tick();
    mem_read_x = 1'b0;
    chk("x_oob_data", x_rdata, '0);
    chk("x_oob_err", WW'(err), WW'(1));
    host_rd(2'd3, 16'd0);

    // done, then final O read returns to IDLE
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("done_busy", WW'(busy), WW'(0));
    host_rd(2'd2, 16'd15);
    chk("o15", host_rdata, WW'(15));
    chk("idle_busy", WW'(busy), WW'(0));

    // New job, then reset mid-job with a write held high
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("job2_busy", WW'(busy), WW'(1));
    chk("job2_count", WW'(wr_count), WW'(0));
    mem_write = 1'b1; mem_write_addr = 32'h70; mem_wdata = WW'(16'hDEAD);
    srstn = 1'b0;
    #1;
    chk("midrst_busy", WW'(busy), WW'(0));
    chk("midrst_count", WW'(wr_count), WW'(0));
    tick(); tick();
    mem_write = 1'b0;
    srstn = 1'b1;
    tick();
    host_rd(2'd2, 16'd7);
    chk("o7_not_written", host_rdata, WW'(7));
    w_addr = 32'h50; mem_read_w = 1'b1;
    tick();
    mem_read_w = 1'b0;
    chk("w_retained", w_rdata, WW'(2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
